simd_instr_encoder: RTL and testbench
=====================================

// Module: simd_instr_encoder
// PURPOSE
//  Packed-SIMD (P-extension, OP-P major opcode) instruction encoder: the inverse of the decoder's
//  OP-P path. Accepts (fu_op, rd, rs1, rs2, repeat) requests, buffers them in a small FIFO and emits
//  legal 32-bit R-type words over a valid/ready stream. Feeds the instruction injection / self-test
//  path ahead of the frontend; a decoder on the same words must recover the same fu_op.
// PARAMETERS
//  FIFO_DEPTH  4            request FIFO entries; power of two, >= 2
//  OPCODE      7'b1110111   major opcode placed in instr[6:0]
//  SKIP_X0     1            1: rd auto-increment skips x0 (31 -> 1); 0: wraps 31 -> 0
// PORTS
//  clk_i          in   1    clock
//  rst_ni         in   1    asynchronous reset, active low
//  flush_i        in   1    drop all queued/in-flight work
//  req_valid_i    in   1    request valid
//  req_ready_o    out  1    request accepted when valid & ready
//  req_op_i       in   fu_op (ariane_pkg)  operation to encode
//  req_rd_i       in   5    destination register (first word)
//  req_rs1_i      in   5    source 1
//  req_rs2_i      in   5    source 2
//  req_repeat_i   in   4    extra copies to emit (0 = one word, 15 = sixteen words)
//  instr_valid_o  out  1    instr_o valid
//  instr_ready_i  in   1    consumer accepts word when valid & ready
//  instr_o        out  32   {funct7, rs2, rs1, 3'b000, rd, OPCODE}
//  instr_last_o   out  1    current word is the last of its request
//  illegal_o      out  1    1-cycle pulse: popped request had unsupported op (dropped)
//  busy_o         out  1    FIFO non-empty or FSM not IDLE
//  illegal_cnt_o  out  16   saturating count of illegal requests (only with macro)
// BEHAVIOUR
//  Reset (async, rst_ni=0): FIFO empty, FSM IDLE, all outputs 0 except req_ready_o=1.
//  req_ready_o = (count < FIFO_DEPTH), from registered count only; no comb path from instr_ready_i.
//  funct7 map: RADD16 0000000 RSUB16 0000001 RADD8 0000100 RSUB8 0000101 KADD16 0001000 KSUB16 0001001
//   KADD8 0001100 KSUB8 0001101 URADD16 0010000 URSUB16 0010001 URADD8 0010100 URSUB8 0010101
//   UKADD16 0011000 UKSUB16 0011001 UKADD8 0011100 UKSUB8 0011101 ADD16 0100000 SUB16 0100001
//   CRAS16 0100010 CRSA16 0100011 ADD8 0100100 SUB8 0100101 SMUL8 1010100 UMUL8 1011100; other ops illegal.
//  FSM IDLE: FIFO non-empty -> pop head; legal -> latch word, rem=repeat, go EMIT; illegal -> pulse
//   illegal_o, stay IDLE. EMIT: instr_valid_o=1, instr_o/instr_last_o held stable until handshake.
//   On handshake: rem==0 -> IDLE; else rem--, rd=rd+1 mod 32 (SKIP_X0: 0->1), rs1/rs2 unchanged, stay EMIT.
//  instr_last_o = (rem==0) while EMIT. Latency: push cycle N -> instr_valid_o at N+2 (empty FIFO).
//  Throughput: 1 word/cycle within a request; one IDLE bubble between requests.
//  Simultaneous push+pop: both occur; count unchanged. Full: push ignored (ready=0).
//  flush_i: FIFO cleared, FSM->IDLE, instr_valid_o=0 next cycle; same-cycle push discarded; flush
//   beats handshake (a word handshaked in the flush cycle still counts as consumed downstream).
//  Reset mid-EMIT: word abandoned, all state to reset values immediately.
// CONFIGURATION
//  SIMD_ENC_ILLEGAL_CNT_EN defined: illegal_cnt_o present; +1 per illegal_o pulse, saturates at
//   16'hFFFF, cleared by reset only (not flush). Undefined: port absent, no counter logic.
// TESTING
//  1. ADD16 rd=3 rs1=1 rs2=2 rep=0 -> instr_o=32'h402081F7, last=1, valid 2 cycles after push, busy 0 after.
//  2. SMUL8 rd=30 rs1=1 rs2=2 rep=2, ready=1 -> 32'hA8208F77, 32'hA8208FF7, 32'hA82080F7 (x0 skipped), last on 3rd.
//  3. Hold instr_ready_i=0 10 cycles, push 5 reqs -> instr_o stable, req_ready_o=0 after 4 queued; release -> all drain in order.
//  4. Push non-SIMD op (e.g. ADD) then SUB8 rd=3 rs1=1 rs2=2 -> illegal_o 1 cycle, no word; then
//     32'h4A2081F7; illegal_cnt_o=1 with macro.
//  5. UKADD8 rep=7, flush_i after 2nd handshake with 2 reqs queued -> valid=0 next cycle, busy_o=0, req_ready_o=1.
//  6. rst_ni low mid-repeat -> all outputs reset at once; after release ADD16 encodes as in test 1.

Source files
------------

// File: rtl/simd_instr_encoder.sv
// simd_instr_encoder: packed-SIMD (OP-P) R-type instruction encoder.
// Requests (fu_op, rd, rs1, rs2, repeat) are queued in a small FIFO. A two-state
// FSM pops them and streams {funct7, rs2, rs1, 3'b000, rd, OPCODE} words over a
// valid/ready interface, incrementing rd on each repeated copy.
// Optional feature macro: SIMD_ENC_ILLEGAL_CNT_EN adds illegal_cnt_o, a saturating
// count of dropped (unsupported) requests.

package simd_enc_pkg;
  // Operation codes: a few scalar ops (not encodable here) followed by the SIMD set.
  typedef enum logic [4:0] {
    ADD, SUB, XORL, ORL,
    RADD16, RSUB16, RADD8, RSUB8, KADD16, KSUB16, KADD8, KSUB8,
    URADD16, URSUB16, URADD8, URSUB8, UKADD16, UKSUB16, UKADD8, UKSUB8,
    ADD16, SUB16, CRAS16, CRSA16, ADD8, SUB8, SMUL8, UMUL8
  } fu_op;
endpackage

module simd_instr_encoder
  import simd_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  OPCODE     = 7'b1110111,
  parameter bit          SKIP_X0    = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fu_op        req_op_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [3:0]  req_repeat_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_last_o,
  output logic        illegal_o,
  output logic        busy_o
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
  ,
  output logic [15:0] illegal_cnt_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    fu_op       op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] rep;
  } req_t;

  typedef enum logic {IDLE, EMIT} state_e;

  // {legal, funct7} for an operation; unsupported ops return legal = 0.
  function automatic logic [7:0] encode_f7(input fu_op op);
    case (op)
      RADD16:  return {1'b1, 7'b0000000};
      RSUB16:  return {1'b1, 7'b0000001};
      RADD8:   return {1'b1, 7'b0000100};
      RSUB8:   return {1'b1, 7'b0000101};
      KADD16:  return {1'b1, 7'b0001000};
      KSUB16:  return {1'b1, 7'b0001001};
      KADD8:   return {1'b1, 7'b0001100};
      KSUB8:   return {1'b1, 7'b0001101};
      URADD16: return {1'b1, 7'b0010000};
      URSUB16: return {1'b1, 7'b0010001};
      URADD8:  return {1'b1, 7'b0010100};
      URSUB8:  return {1'b1, 7'b0010101};
      UKADD16: return {1'b1, 7'b0011000};
      UKSUB16: return {1'b1, 7'b0011001};
      UKADD8:  return {1'b1, 7'b0011100};
      UKSUB8:  return {1'b1, 7'b0011101};
      ADD16:   return {1'b1, 7'b0100000};
      SUB16:   return {1'b1, 7'b0100001};
      CRAS16:  return {1'b1, 7'b0100010};
      CRSA16:  return {1'b1, 7'b0100011};
      ADD8:    return {1'b1, 7'b0100100};
      SUB8:    return {1'b1, 7'b0100101};
      SMUL8:   return {1'b1, 7'b1010100};
      UMUL8:   return {1'b1, 7'b1011100};
      default: return 8'h00;
    endcase
  endfunction

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [4:0]       rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_inc;
  logic [3:0]       rem_q, rem_d;
  logic             illegal_q, illegal_d;
  logic             push, pop, handshake;
  logic [7:0]       head_code;
  req_t             head, req_in;

  assign req_ready_o   = (count_q < DEPTH_C);
  assign instr_valid_o = (state_q == EMIT);
  assign instr_o       = instr_valid_o ? {funct7_q, rs2_q, rs1_q, 3'b000, rd_q, OPCODE} : 32'h0;
  assign instr_last_o  = instr_valid_o && (rem_q == 4'd0);
  assign illegal_o     = illegal_q;
  assign busy_o        = (count_q != '0) || (state_q != IDLE);

  assign req_in    = '{op: req_op_i, rd: req_rd_i, rs1: req_rs1_i, rs2: req_rs2_i, rep: req_repeat_i};
  assign head      = fifo_mem[rd_ptr_q];
  assign head_code = encode_f7(head.op);
  assign push      = req_valid_i && req_ready_o && !flush_i;
  assign pop       = (state_q == IDLE) && (count_q != '0) && !flush_i;
  assign handshake = instr_valid_o && instr_ready_i;
  assign rd_inc    = (SKIP_X0 && (rd_q == 5'd31)) ? 5'd1 : rd_q + 5'd1;

  // FIFO storage: no reset needed, validity is tracked by count/pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= req_in;
  end

  // Next-state: FIFO bookkeeping, pop/emit FSM, flush override last.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    state_d   = state_q;
    funct7_d  = funct7_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rem_d     = rem_q;
    illegal_d = 1'b0;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (head_code[7]) begin
        state_d  = EMIT;
        funct7_d = head_code[6:0];
        rd_d     = head.rd;
        rs1_d    = head.rs1;
        rs2_d    = head.rs2;
        rem_d    = head.rep;
      end else begin
        illegal_d = 1'b1;
      end
    end
    if ((state_q == EMIT) && handshake) begin
      if (rem_q == 4'd0) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_q - 4'd1;
        rd_d  = rd_inc;
      end
    end
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      state_d   = IDLE;
      illegal_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      funct7_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rem_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      funct7_q  <= funct7_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rem_q     <= rem_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef SIMD_ENC_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_q;

  // Saturating illegal-request counter; survives flush, cleared by reset only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_cnt_q <= '0;
    end else if (illegal_d && (illegal_cnt_q != 16'hFFFF)) begin
      illegal_cnt_q <= illegal_cnt_q + 16'd1;
    end
  end

  assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_simd_instr_encoder.sv
// Testbench for simd_instr_encoder: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_simd_instr_encoder;
  import simd_enc_pkg::*;

  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic        req_valid_i = 1'b0, instr_ready_i = 1'b0;
  fu_op        req_op_i = ADD;
  logic [4:0]  req_rd_i = '0, req_rs1_i = '0, req_rs2_i = '0;
  logic [3:0]  req_repeat_i = '0;
  logic        req_ready_o, instr_valid_o, instr_last_o, illegal_o, busy_o;
  logic [31:0] instr_o;
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt_o;
  logic [15:0] cnt_before;
`endif

  simd_instr_encoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
    .req_repeat_i(req_repeat_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .instr_last_o(instr_last_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
    , .illegal_cnt_o(illegal_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // ---------------- reference model ----------------
  int f7_map[string];
  typedef struct { logic [31:0] w; bit last; } exp_t;
  exp_t exp_q[$];
  int   exp_ill;

  function automatic logic [31:0] model_word(fu_op op, int rd, int rs1, int rs2);
    longint w;
    w = longint'(f7_map[op.name()]) * (longint'(1) << 25) + rs2 * (1 << 20)
        + rs1 * (1 << 15) + rd * (1 << 7) + 'h77;
    return 32'(w);
  endfunction

  function automatic void model_push(fu_op op, int rd, int rs1, int rs2, int rep);
    int r = rd;
    if (!f7_map.exists(op.name())) begin
      exp_ill++;
      return;
    end
    for (int k = 0; k <= rep; k++) begin
      exp_q.push_back('{w: model_word(op, r, rs1, rs2), last: (k == rep)});
      r = (r + 1) % 32;
      if (r == 0) r = 1;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [31:0] got_w[$];
  bit          got_l[$];
  int          got_c[$];
  int          got_ill;

  task automatic push_req(input fu_op op, input int rd, input int rs1, input int rs2,
                          input int rep, output bit acc);
    req_op_i = op; req_rd_i = 5'(rd); req_rs1_i = 5'(rs1); req_rs2_i = 5'(rs2);
    req_repeat_i = 4'(rep); req_valid_i = 1'b1;
    acc = req_ready_o;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic observe(input int n);
    got_w.delete(); got_l.delete(); got_c.delete(); got_ill = 0;
    for (int i = 0; i < n; i++) begin
      if (instr_valid_o && instr_ready_i) begin
        got_w.push_back(instr_o); got_l.push_back(instr_last_o); got_c.push_back(i);
      end
      if (illegal_o) got_ill++;
      @(negedge clk_i);
    end
  endtask

  typedef struct { fu_op op; logic [31:0] exp_w; bit exp_ill; } vec_t;
  vec_t tbl[8];

  initial begin
    bit acc;
    int bad, hs, guard, obs_ill;
    exp_t e;

    f7_map["RADD16"] = 7'b0000000;  f7_map["RSUB16"] = 7'b0000001;
    f7_map["RADD8"] = 7'b0000100;   f7_map["RSUB8"] = 7'b0000101;
    f7_map["KADD16"] = 7'b0001000;  f7_map["KSUB16"] = 7'b0001001;
    f7_map["KADD8"] = 7'b0001100;   f7_map["KSUB8"] = 7'b0001101;
    f7_map["URADD16"] = 7'b0010000; f7_map["URSUB16"] = 7'b0010001;
    f7_map["URADD8"] = 7'b0010100;  f7_map["URSUB8"] = 7'b0010101;
    f7_map["UKADD16"] = 7'b0011000; f7_map["UKSUB16"] = 7'b0011001;
    f7_map["UKADD8"] = 7'b0011100;  f7_map["UKSUB8"] = 7'b0011101;
    f7_map["ADD16"] = 7'b0100000;   f7_map["SUB16"] = 7'b0100001;
    f7_map["CRAS16"] = 7'b0100010;  f7_map["CRSA16"] = 7'b0100011;
    f7_map["ADD8"] = 7'b0100100;    f7_map["SUB8"] = 7'b0100101;
    f7_map["SMUL8"] = 7'b1010100;   f7_map["UMUL8"] = 7'b1011100;

    // rd=3 rs1=1 rs2=2 rep=0 for every table row
    tbl[0] = '{RADD16, 32'h002081F7, 1'b0};
    tbl[1] = '{KADD16, 32'h102081F7, 1'b0};
    tbl[2] = '{UKSUB8, 32'h3A2081F7, 1'b0};
    tbl[3] = '{CRAS16, 32'h442081F7, 1'b0};
    tbl[4] = '{UMUL8,  32'hB82081F7, 1'b0};
    tbl[5] = '{URSUB8, 32'h2A2081F7, 1'b0};
    tbl[6] = '{ADD16,  32'h402081F7, 1'b0};
    tbl[7] = '{XORL,   32'h00000000, 1'b1};

    // ---- reset state ----
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_last", instr_last_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_busy", busy_o, 0);
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
    chk("rst_illegal_cnt", illegal_cnt_o, 0);
`endif
    rst_ni = 1'b1;
    instr_ready_i = 1'b1;
    @(negedge clk_i);

    // ---- single ADD16: latency and encoding ----
    push_req(ADD16, 3, 1, 2, 0, acc);
    chk("t1_valid_n1", instr_valid_o, 0);
    @(negedge clk_i);
    chk("t1_valid_n2", instr_valid_o, 1);
    chk("t1_word", instr_o, 32'h402081F7);
    chk("t1_last", instr_last_o, 1);
    @(negedge clk_i);
    chk("t1_valid_after", instr_valid_o, 0);
    chk("t1_busy_after", busy_o, 0);

    // ---- vector table ----
    foreach (tbl[i]) begin
      push_req(tbl[i].op, 3, 1, 2, 0, acc);
      observe(5);
      chk($sformatf("tbl%0d_%s_illegal", i, tbl[i].op.name()), got_ill, tbl[i].exp_ill);
      chk($sformatf("tbl%0d_%s_nwords", i, tbl[i].op.name()), got_w.size(), !tbl[i].exp_ill);
      if (got_w.size() > 0) begin
        chk($sformatf("tbl%0d_%s_word", i, tbl[i].op.name()), got_w[0], tbl[i].exp_w);
        chk($sformatf("tbl%0d_%s_last", i, tbl[i].op.name()), got_l[0], 1);
      end
    end

    // ---- SMUL8 repeat with x0 skip ----
    push_req(SMUL8, 30, 1, 2, 2, acc);
    observe(6);
    chk("t2_nwords", got_w.size(), 3);
    if (got_w.size() == 3) begin
      chk("t2_word0", got_w[0], 32'hA8208F77);
      chk("t2_word1", got_w[1], 32'hA8208FF7);
      chk("t2_word2", got_w[2], 32'hA82080F7);
      chk("t2_lasts", {got_l[0], got_l[1], got_l[2]}, 3'b001);
      chk("t2_back_to_back", got_c[2] - got_c[0], 2);
    end

    // ---- backpressure: 5 requests, FIFO full, stable output ----
    instr_ready_i = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      fu_op ops3[5] = '{ADD16, KSUB8, UMUL8, CRSA16, URADD16};
      push_req(ops3[i], 5 + i, 7, 9, 0, acc);
      if (!acc) bad++;
      model_push(ops3[i], 5 + i, 7, 9, 0);
    end
    chk("t3_all_accepted", bad, 0);
    chk("t3_ready_full", req_ready_o, 0);
    push_req(ADD8, 20, 20, 20, 0, acc);
    chk("t3_full_push_ignored", acc, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(instr_valid_o && instr_o == exp_q[0].w && !req_ready_o)) bad++;
      @(negedge clk_i);
    end
    chk("t3_stable_held", bad, 0);
    instr_ready_i = 1'b1;
    observe(20);
    chk("t3_nwords", got_w.size(), 5);
    for (int i = 0; i < 5 && i < got_w.size(); i++)
      chk($sformatf("t3_word%0d", i), got_w[i], exp_q[i].w);
    exp_q.delete();

    // ---- illegal op followed by SUB8 ----
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
    cnt_before = illegal_cnt_o;
`endif
    push_req(ADD, 3, 1, 2, 0, acc);
    push_req(SUB8, 3, 1, 2, 0, acc);
    observe(8);
    chk("t4_illegal_pulse_cycles", got_ill, 1);
    chk("t4_nwords", got_w.size(), 1);
    if (got_w.size() > 0) chk("t4_word", got_w[0], 32'h4A2081F7);
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
    chk("t4_illegal_cnt_delta", illegal_cnt_o - cnt_before, 1);
`endif

    // ---- flush mid-request with queued work and a same-cycle push ----
    push_req(UKADD8, 4, 5, 6, 7, acc);
    push_req(ADD8, 1, 1, 1, 0, acc);
    push_req(SUB16, 2, 2, 2, 0, acc);
    hs = 0; guard = 0;
    while (hs < 2 && guard < 20) begin
      if (instr_valid_o && instr_ready_i) hs++;
      @(negedge clk_i);
      guard++;
    end
    chk("t5_two_handshakes", hs, 2);
    flush_i = 1'b1;
    req_op_i = ADD16; req_repeat_i = 4'd0; req_valid_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0; req_valid_i = 1'b0;
    chk("t5_valid_after_flush", instr_valid_o, 0);
    chk("t5_busy_after_flush", busy_o, 0);
    chk("t5_ready_after_flush", req_ready_o, 1);
    observe(6);
    chk("t5_no_words_after_flush", got_w.size(), 0);

    // ---- asynchronous reset mid-repeat ----
    push_req(UKSUB16, 8, 3, 4, 5, acc);
    hs = 0; guard = 0;
    while (hs < 2 && guard < 20) begin
      if (instr_valid_o && instr_ready_i) hs++;
      @(negedge clk_i);
      guard++;
    end
    chk("t6_in_emit", instr_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", instr_valid_o, 0);
    chk("t6_rst_instr", instr_o, 0);
    chk("t6_rst_last", instr_last_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_ready", req_ready_o, 1);
`ifdef SIMD_ENC_ILLEGAL_CNT_EN
    chk("t6_rst_illegal_cnt", illegal_cnt_o, 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    push_req(ADD16, 3, 1, 2, 0, acc);
    observe(4);
    chk("t6_post_nwords", got_w.size(), 1);
    if (got_w.size() > 0) chk("t6_post_word", got_w[0], 32'h402081F7);

    // ---- randomized traffic against the reference model ----
    exp_q.delete(); exp_ill = 0; obs_ill = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc < 600) begin
        req_valid_i   = 1'($urandom_range(0, 1));
        req_op_i      = fu_op'(5'($urandom_range(0, 27)));
        req_rd_i      = 5'($urandom_range(0, 31));
        req_rs1_i     = 5'($urandom_range(0, 31));
        req_rs2_i     = 5'($urandom_range(0, 31));
        req_repeat_i  = 4'($urandom_range(0, 3));
        instr_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        if (!busy_o && !illegal_o && exp_q.size() == 0) break;
      end
      if (req_valid_i && req_ready_o)
        model_push(req_op_i, int'(req_rd_i), int'(req_rs1_i), int'(req_rs2_i), int'(req_repeat_i));
      if (instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_word", instr_o, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_word", instr_o, e.w);
          chk("rnd_last", instr_last_o, e.last);
        end
      end
      if (illegal_o) obs_ill++;
      @(negedge clk_i);
    end
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_illegal_count", obs_ill, exp_ill);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
